// File: rtl/multiword_add_seq_if.sv
// rtl/multiword_add_seq_if.sv - start/busy/done operand and result bundle for multiword_add_seq (op exists only with MWADD_SUB_EN)
interface multiword_add_seq_if #(
    parameter int WORDS = 4
);
    logic                   start;
    logic [16*WORDS-1:0]    a_in;
    logic [16*WORDS-1:0]    b_in;
    logic                   ci_in;
`ifdef MWADD_SUB_EN
    logic                   op;
`endif
    logic                   busy;
    logic                   done;
    logic [16*WORDS-1:0]    sum;
    logic                   co;
    logic                   ovf;

    // requester side: drives the operation, observes status and result
    modport master (
`ifdef MWADD_SUB_EN
        output op,
`endif
        output start, a_in, b_in, ci_in,
        input  busy, done, sum, co, ovf
    );

    // sequencer side
    modport slave (
`ifdef MWADD_SUB_EN
        input  op,
`endif
        input  start, a_in, b_in, ci_in,
        output busy, done, sum, co, ovf
    );
endinterface

// File: rtl/multiword_add_seq.sv
// rtl/multiword_add_seq.sv - word-serial multi-precision adder on one 16-bit adder; MWADD_SUB_EN adds subtract via op
module sixteen_bit_adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        Ci,
    output logic [15:0] S,
    output logic        Co
);
    // plain 16-bit ripple add with carry in/out
    assign {Co, S} = {1'b0, a} + {1'b0, b} + {16'd0, Ci};
endmodule

module multiword_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    multiword_add_seq_if.slave    bus
);
    localparam int W = 16 * WORDS;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] LAST = 4'(WORDS - 1);

    logic [1:0]   state;
    logic [3:0]   k;
    logic         c;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] sum_q;
    logic         busy_q;
    logic         done_q;
    logic         co_q;
    logic         ovf_q;
`ifdef MWADD_SUB_EN
    logic         op_q;
`endif

    logic [15:0]  a_word;
    logic [15:0]  b_word;
    logic [15:0]  beff;
    logic [15:0]  s;
    logic         co_w;
    logic         accept;
    logic         init_c;

    // start is only honoured when no operation is running (IDLE or DONE)
    assign accept = bus.start && (state != RUN);

    // select the current word pair; subtraction feeds the inverted B word
    always_comb begin
        a_word = a_q[k*16 +: 16];
        b_word = b_q[k*16 +: 16];
`ifdef MWADD_SUB_EN
        beff   = op_q ? ~b_word : b_word;
        init_c = bus.op ? 1'b1 : bus.ci_in;
`else
        beff   = b_word;
        init_c = bus.ci_in;
`endif
    end

    sixteen_bit_adder u_adder (
        .a  (a_word),
        .b  (beff),
        .Ci (c),
        .S  (s),
        .Co (co_w)
    );

    // sequencer: accept, walk words LSW first with registered carry, then pulse done
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            k      <= 4'd0;
            c      <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            co_q   <= 1'b0;
            ovf_q  <= 1'b0;
`ifdef MWADD_SUB_EN
            op_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                RUN: begin
                    sum_q[k*16 +: 16] <= s;
                    c                 <= co_w;
                    if (k == LAST) begin
                        co_q   <= co_w;
                        ovf_q  <= (a_word[15] == beff[15]) && (s[15] != a_word[15]);
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        k <= k + 4'd1;
                    end
                end
                default: begin
                    if (accept) begin
                        a_q    <= bus.a_in;
                        b_q    <= bus.b_in;
                        k      <= 4'd0;
                        c      <= init_c;
                        state  <= RUN;
                        busy_q <= 1'b1;
`ifdef MWADD_SUB_EN
                        op_q   <= bus.op;
`endif
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.co   = co_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_multiword_add_seq.sv
// tb/tb_multiword_add_seq.sv - randomized self-checking bench for multiword_add_seq (MWADD_SUB_EN enables subtract tests)
module tb_multiword_add_seq;
    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;
`ifdef MWADD_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err    = 0;

    multiword_add_seq_if #(.WORDS(WORDS)) bus ();

    multiword_add_seq #(.WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // full-width reference: {ovf, co, sum} of A +/- B
    function automatic logic [W+1:0] ref_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic ci, input logic op);
        logic [W-1:0] be;
        logic         cin;
        logic [W:0]   r;
        logic         v;
        be  = (SUB_EN && op) ? ~b : b;
        cin = (SUB_EN && op) ? 1'b1 : ci;
        r   = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, cin};
        v   = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
        return {v, r};
    endfunction

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] v;
        for (int i = 0; i < WORDS; i++) begin
            case ($urandom_range(0, 3))
                0:       v[i*16 +: 16] = 16'hFFFF;
                1:       v[i*16 +: 16] = 16'h0000;
                default: v[i*16 +: 16] = 16'($urandom);
            endcase
        end
        return v;
    endfunction

    // drive one operation, scramble operands after acceptance, observe result
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         output int lat, output int bcnt, output logic [W-1:0] s,
                         output logic c, output logic v, output logic d2);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_in  = a;
        bus.b_in  = b;
        bus.ci_in = ci;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a_in  = rand_vec();
        bus.b_in  = rand_vec();
        bus.ci_in = ~ci;
        lat  = 1;
        bcnt = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            if (bus.busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
        s = bus.sum;
        c = bus.co;
        v = bus.ovf;
        @(negedge clk);
        d2 = bus.done;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.co, bus.ovf} !== 4'b0 || bus.sum !== '0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b done=%b co=%b ovf=%b sum=%h, want all zero",
                     bus.busy, bus.done, bus.co, bus.ovf, bus.sum);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [6];
        logic [W-1:0] tb [6];
        logic         tc [6];
        logic [W-1:0] es [6];
        logic         eco[6];
        logic         eov[6];
        int lat, bcnt;
        logic [W-1:0] s;
        logic c, v, d2;
        ta[0] = 64'h000A;                tb[0] = 64'h0006; tc[0] = 0; es[0] = 64'h0010;                eco[0] = 0; eov[0] = 0;
        ta[1] = 64'hFFFF;                tb[1] = 64'h0001; tc[1] = 0; es[1] = 64'h1_0000;              eco[1] = 0; eov[1] = 0;
        ta[2] = '1;                      tb[2] = 64'h0001; tc[2] = 0; es[2] = 64'h0;                   eco[2] = 1; eov[2] = 0;
        ta[3] = 64'h7FFF_FFFF_FFFF_FFFF; tb[3] = 64'h0001; tc[3] = 0; es[3] = 64'h8000_0000_0000_0000; eco[3] = 0; eov[3] = 1;
        ta[4] = 64'h7FFF_FFFF_FFFF_FFFF; tb[4] = 64'h0000; tc[4] = 1; es[4] = 64'h8000_0000_0000_0000; eco[4] = 0; eov[4] = 1;
        ta[5] = 64'h8000_0000_0000_0000; tb[5] = 64'h8000_0000_0000_0000; tc[5] = 0; es[5] = 64'h0;   eco[5] = 1; eov[5] = 1;
        for (int i = 0; i < 6; i++) begin
            do_op(ta[i], tb[i], tc[i], lat, bcnt, s, c, v, d2);
            n_checks += 4;
            if (lat != WORDS + 1) begin
                n_err++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, WORDS + 1);
            end
            if (bcnt != WORDS) begin
                n_err++; $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, bcnt, WORDS);
            end
            if ({s, c, v} !== {es[i], eco[i], eov[i]}) begin
                n_err++; $display("FAIL dir%0d_result: sum=%h co=%b ovf=%b want sum=%h co=%b ovf=%b",
                                  i, s, c, v, es[i], eco[i], eov[i]);
            end
            if (d2 !== 1'b0) begin
                n_err++; $display("FAIL dir%0d_done_pulse: done=%b next cycle, want 0", i, d2);
            end
        end
    endtask

    task automatic test_random();
        int lat, bcnt;
        logic [W-1:0] a, b, s;
        logic ci, op, c, v, d2;
        logic [W+1:0] e;
        for (int i = 0; i < 25; i++) begin
            a  = rand_vec();
            b  = rand_vec();
            ci = 1'($urandom);
            op = SUB_EN ? 1'($urandom) : 1'b0;
`ifdef MWADD_SUB_EN
            bus.op = op;
`endif
            e = ref_calc(a, b, ci, op);
            do_op(a, b, ci, lat, bcnt, s, c, v, d2);
            n_checks += 2;
            if (lat != WORDS + 1) begin
                n_err++; $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, WORDS + 1);
            end
            if ({v, c, s} !== e) begin
                n_err++; $display("FAIL rand%0d_result: a=%h b=%h ci=%b op=%b got ovf=%b co=%b sum=%h want ovf=%b co=%b sum=%h",
                                  i, a, b, ci, op, v, c, s, e[W+1], e[W], e[W-1:0]);
            end
        end
`ifdef MWADD_SUB_EN
        bus.op = 1'b0;
`endif
    endtask

    task automatic test_back_to_back();
        logic [W+1:0] q[$];
        logic [W+1:0] e;
        logic [W-1:0] a, b;
        logic ci;
        bit exp_done;
        for (int cyc = 0; cyc <= 25; cyc++) begin
            @(negedge clk);
            exp_done = (cyc > 0) && (cyc % (WORDS + 1) == 0);
            n_checks++;
            if (bus.done !== exp_done) begin
                n_err++; $display("FAIL b2b_done_c%0d: done=%b want %b", cyc, bus.done, exp_done);
            end
            if (exp_done && bus.done === 1'b1) begin
                e = q.pop_front();
                n_checks++;
                if ({bus.ovf, bus.co, bus.sum} !== e) begin
                    n_err++; $display("FAIL b2b_result_c%0d: ovf=%b co=%b sum=%h want ovf=%b co=%b sum=%h",
                                      cyc, bus.ovf, bus.co, bus.sum, e[W+1], e[W], e[W-1:0]);
                end
            end
            a  = rand_vec();
            b  = rand_vec();
            ci = 1'($urandom);
            bus.a_in  = a;
            bus.b_in  = b;
            bus.ci_in = ci;
            bus.start = (cyc <= 20);
            if (cyc <= 20 && cyc % (WORDS + 1) == 0) q.push_back(ref_calc(a, b, ci, 1'b0));
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int lat, bcnt;
        logic [W-1:0] s;
        logic c, v, d2;
        logic [W+1:0] e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_in  = '1;
        bus.b_in  = 64'h0001_0001_0001_0001;
        bus.ci_in = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({bus.busy, bus.done, bus.co, bus.ovf} !== 4'b0 || bus.sum !== '0) begin
            n_err++;
            $display("FAIL midrun_reset: busy=%b done=%b co=%b ovf=%b sum=%h, want all zero",
                     bus.busy, bus.done, bus.co, bus.ovf, bus.sum);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                n_err++; $display("FAIL midrun_no_done_%0d: done=%b busy=%b want 0 0", i, bus.done, bus.busy);
            end
        end
        e = ref_calc(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0);
        do_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, lat, bcnt, s, c, v, d2);
        n_checks++;
        if ({v, c, s} !== e || lat != WORDS + 1) begin
            n_err++; $display("FAIL after_reset_op: sum=%h co=%b ovf=%b lat=%0d want sum=%h co=%b ovf=%b lat=%0d",
                              s, c, v, lat, e[W-1:0], e[W], e[W+1], WORDS + 1);
        end
    endtask

`ifdef MWADD_SUB_EN
    task automatic test_subtract();
        int lat, bcnt;
        logic [W-1:0] s;
        logic c, v, d2;
        bus.op = 1'b1;
        do_op(64'd5, 64'd7, 1'b0, lat, bcnt, s, c, v, d2);
        n_checks++;
        if ({s, c} !== {64'hFFFF_FFFF_FFFF_FFFE, 1'b0}) begin
            n_err++; $display("FAIL sub_5_7: sum=%h co=%b want sum=fffffffffffffffe co=0", s, c);
        end
        do_op(64'd7, 64'd5, 1'b1, lat, bcnt, s, c, v, d2);
        n_checks++;
        if ({s, c} !== {64'd2, 1'b1}) begin
            n_err++; $display("FAIL sub_7_5: sum=%h co=%b want sum=2 co=1", s, c);
        end
        bus.op = 1'b0;
    endtask
`endif

    initial begin
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        bus.ci_in = 1'b0;
`ifdef MWADD_SUB_EN
        bus.op    = 1'b0;
`endif
        repeat (2) @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
`ifdef MWADD_SUB_EN
        test_subtract();
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
